// File: rtl/audio_decim_fir_if.sv
// Sample/coefficient bus between the FM demodulator side and audio_decim_fir.
// master drives samples and coefficient writes; slave is the filter.
interface audio_decim_fir_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32
);
  logic                          start;
  logic signed [DATA_WIDTH-1:0]  din;
  logic                          coef_wr;
  logic [$clog2(TAPS)-1:0]       coef_addr;
  logic signed [DATA_WIDTH-1:0]  coef_data;
  logic                          ready;
  logic                          done;
  logic signed [DATA_WIDTH-1:0]  dout;
  logic                          overrun;

  modport master (output start, din, coef_wr, coef_addr, coef_data,
                  input  ready, done, dout, overrun);
  modport slave  (input  start, din, coef_wr, coef_addr, coef_data,
                  output ready, done, dout, overrun);
endinterface

// File: rtl/audio_decim_fir.sv
// Decimating FIR with one time-shared MAC: TAPS cycles per output, TAPS+2 start-to-done.
// Define DECIM_FIR_SAT_EN to clamp the scaled result instead of wrapping it.
module audio_decim_fir #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIM      = 8,
  parameter int FRAC_BITS  = 10
) (
  input logic              clock,
  input logic              reset,
  audio_decim_fir_if.slave bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = 2*DATA_WIDTH + AW;
  localparam int DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [ACC_W-1:0] RND = ACC_W'((64'd1 << FRAC_BITS) - 64'd1);
  localparam logic signed [ACC_W-1:0] Q_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Q_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                          state_q, state_d;
  logic [TAPS-1:0][DATA_WIDTH-1:0]     buf_q, buf_d;
  logic [TAPS-1:0][DATA_WIDTH-1:0]     coef_q, coef_d;
  logic [AW-1:0]                       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                       tap_q, tap_d;
  logic [DCW-1:0]                      dec_cnt_q, dec_cnt_d;
  logic signed [ACC_W-1:0]             acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]        q_q, q_d;
  logic signed [DATA_WIDTH-1:0]        dout_q, dout_d;
  logic                                done_q, done_d;
  logic                                overrun_q, overrun_d;

  logic [AW-1:0]                       rd_idx;
  logic signed [2*DATA_WIDTH-1:0]      prod;
  logic signed [ACC_W-1:0]             q_full;

  // wr_ptr already points past the newest sample, so tap k sits k+1 behind it
  assign rd_idx = wr_ptr_q - AW'(1) - tap_q;
  assign prod   = $signed(coef_q[tap_q]) * $signed(buf_q[rd_idx]);

  // Bias negatives before the shift so the quotient truncates toward zero
  assign q_full = $signed(acc_q + (acc_q[ACC_W-1] ? RND : '0)) >>> FRAC_BITS;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    coef_d    = coef_q;
    wr_ptr_d  = wr_ptr_q;
    tap_d     = tap_q;
    dec_cnt_d = dec_cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (bus.start & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (bus.coef_wr) coef_d[bus.coef_addr] = bus.coef_data;
        if (bus.start) begin
          buf_d[wr_ptr_q] = bus.din;
          wr_ptr_d        = wr_ptr_q + AW'(1);
          if (dec_cnt_q == DCW'(DECIM-1)) begin
            dec_cnt_d = '0;
            tap_d     = '0;
            acc_d     = '0;
            state_d   = S_MAC;
          end else begin
            dec_cnt_d = dec_cnt_q + DCW'(1);
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{AW{prod[2*DATA_WIDTH-1]}}, prod};
        tap_d = tap_q + AW'(1);
        if (tap_q == AW'(TAPS-1)) state_d = S_SCALE;
      end
      S_SCALE: begin
`ifdef DECIM_FIR_SAT_EN
        if (q_full > Q_MAX)      q_d = DATA_WIDTH'(Q_MAX);
        else if (q_full < Q_MIN) q_d = DATA_WIDTH'(Q_MIN);
        else                     q_d = DATA_WIDTH'(q_full);
`else
        q_d = DATA_WIDTH'(q_full);
`endif
        state_d = S_OUT;
      end
      default: begin
        dout_d  = q_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      coef_q    <= '0;
      wr_ptr_q  <= '0;
      tap_q     <= '0;
      dec_cnt_q <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      coef_q    <= coef_d;
      wr_ptr_q  <= wr_ptr_d;
      tap_q     <= tap_d;
      dec_cnt_q <= dec_cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.ready   = (state_q == S_IDLE);
  assign bus.done    = done_q;
  assign bus.dout    = dout_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_audio_decim_fir.sv
// Scoreboard bench for audio_decim_fir (TAPS=4, DECIM=2): a reference model
// predicts each output and its done cycle when the launching sample is driven.
module tb_audio_decim_fir;
  localparam int DW    = 32;
  localparam int TAPS  = 4;
  localparam int DECIM = 2;
  localparam int LAT   = TAPS + 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  audio_decim_fir_if #(.DATA_WIDTH(DW), .TAPS(TAPS)) bus ();

  audio_decim_fir #(.DATA_WIDTH(DW), .TAPS(TAPS), .DECIM(DECIM), .FRAC_BITS(10)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic signed [DW-1:0] d;
    int                   c;
  } exp_t;

  exp_t                 sb[$];
  int                   n_chk = 0;
  int                   n_err = 0;
  int                   cyc   = 0;
  logic signed [DW-1:0] mhist[TAPS];
  logic signed [DW-1:0] mcoef[TAPS];
  int                   mdec;
  int                   busy_until;
  bit                   mover;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic signed [DW-1:0] model_out();
    logic signed [65:0] acc, mc, mx, q;
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      mc  = mcoef[k];
      mx  = mhist[k];
      acc = acc + mc * mx;
    end
    q = acc / 66'sd1024;
`ifdef DECIM_FIR_SAT_EN
    if (q > 66'sh7FFFFFFF)       q = 66'sh7FFFFFFF;
    else if (q < -66'sh80000000) q = -66'sh80000000;
`endif
    return q[DW-1:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      mhist[k] = '0;
      mcoef[k] = '0;
    end
    mdec = 0; busy_until = 0; mover = 0;
    sb.delete();
  endtask

  // Drive a sample (optionally with a coefficient write) for exactly one edge
  task automatic send(input logic [DW-1:0] v, input bit wr = 1'b0,
                      input int a = 0, input logic [DW-1:0] d = '0);
    int  e;
    bit  idle;
    exp_t x;
    @(negedge clock);
    e    = cyc + 1;
    idle = (e > busy_until);
    bus.start = 1'b1; bus.din = v;
    bus.coef_wr = wr; bus.coef_addr = a[$clog2(TAPS)-1:0]; bus.coef_data = d;
    chk("ready", bus.ready, idle);
    if (idle) begin
      if (wr) mcoef[a] = d;
      for (int k = TAPS-1; k > 0; k--) mhist[k] = mhist[k-1];
      mhist[0] = v;
      if (mdec == DECIM-1) begin
        mdec = 0;
        x.d = model_out(); x.c = e;
        sb.push_back(x);
        busy_until = e + LAT;
      end else begin
        mdec++;
      end
    end else begin
      mover = 1'b1;
    end
    @(negedge clock);
    bus.start = 1'b0; bus.coef_wr = 1'b0;
  endtask

  task automatic wr_coef(input int a, input logic [DW-1:0] d);
    @(negedge clock);
    bus.coef_wr = 1'b1; bus.coef_addr = a[$clog2(TAPS)-1:0]; bus.coef_data = d;
    if (cyc + 1 > busy_until) mcoef[a] = d;
    @(negedge clock);
    bus.coef_wr = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    chk("drain", sb.size(), 0);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (reset && bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        x = sb.pop_front();
        chk("dout", bus.dout, x.d);
        chk("latency", cyc - x.c, LAT);
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.din = '0;
    bus.coef_wr = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    model_reset();
    gap(2);
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_overrun", bus.overrun, 0);
    reset = 1'b1;

    // passband: unity taps, outputs 3 and 10
    for (int k = 0; k < TAPS; k++) wr_coef(k, 32'sd1024);
    for (int s = 1; s <= 4; s++) begin
      send(s);
      gap(8);
    end
    wait_idle();

    // impulse ordering; coef[1] written in the same cycle as the launching start
    do_reset();
    wr_coef(0, 32'sd1024); wr_coef(2, -32'sd1024); wr_coef(3, 32'sd512);
    send(32'sd1024);
    send(0, 1'b1, 1, 32'sd2048);
    wait_idle();
    send(0); send(0);
    wait_idle();
    chk("impulse_overrun", bus.overrun, mover);

    // truncation toward zero: -1/1024 -> 0, -2048/1024 -> -2
    do_reset();
    wr_coef(0, -32'sd1);
    send(0); send(1);
    wait_idle();
    send(0); send(32'sd2048);
    wait_idle();

    // overrun and coefficient lock during MAC
    wr_coef(0, 32'sd1024); wr_coef(1, 32'sd1024);
    send(5); send(7);
    send(99);
    wr_coef(0, 32'sd0);
    wait_idle();
    chk("overrun_set", bus.overrun, mover);
    send(6); send(8);
    wait_idle();
    chk("overrun_sticky", bus.overrun, 1);

    // large operands: clamp or wrap depending on build
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(k, 32'h7FFFFFFF);
    for (int s = 0; s < 4; s++) send(32'h7FFFFFFF);
    wait_idle();

    // reset in the middle of a MAC
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(k, 32'sd1024);
    send(3); send(5);
    gap(2);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    gap(10);
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_ready", bus.ready, 1);
    chk("mid_rst_overrun", bus.overrun, 0);
    for (int k = 0; k < TAPS; k++) wr_coef(k, 32'sd1024);
    send(1); send(2);
    wait_idle();

    gap(4);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
